// File: rtl/interval_timer.sv
// ---------------------------------------------------------------------------
// interval_timer
//
// Programmable interval timer for the traffic-light controller. It holds three
// time parameters (base, extended, yellow) and derives a one-second tick from
// the system clock. A start request loads the selected parameter into a 4-bit
// seconds counter, which then counts down one step per tick. When the counter
// runs out, the block pulses `expired` back to the FSM.
//
// Optional feature (compile-time macro): INTERVAL_CLAMP_EN
//   defined   : stored values of 0 (writes and reset defaults) become 1, so
//               every interval lasts at least one second.
//   undefined : a value of 0 is stored as-is. A start with 0 pulses `expired`
//               on the next edge, and `busy` never rises for it.
//
// Ports
//   clk               in   system clock, rising edge
//   sys_reset         in   asynchronous active-low reset
//   start_timer       in   one-cycle load/start request (restarts if counting)
//   interval_address  in   [1:0] 00 base, 01 extended, 10 yellow, 11 base
//   prg_sync_in       in   synchronized program strobe (level, every clk)
//   time_param_sel    in   [1:0] register to write, 11 = no write
//   time_value        in   [3:0] value to write, in seconds
//   expired           out  one-cycle pulse at the end of an interval
//   busy              out  high while a non-zero interval is counting
//   one_hz_enable     out  one-cycle tick from the prescaler
//   o_dbg_state       out  FSM state (0 IDLE, 1 COUNT) for observation
//
// Protocol between the FSM and this timer: start_timer is a single-cycle
// request that is always accepted unless prg_sync_in is high in the same
// cycle. In that case programming wins and the FSM must reissue the start.
// expired is a single-cycle completion pulse and needs no acknowledge.
// Aborted or restarted intervals never produce expired.
// ---------------------------------------------------------------------------
module interval_timer #(
  parameter int CLK_DIV  = 100_000_000,
  parameter int DEF_BASE = 6,
  parameter int DEF_EXT  = 3,
  parameter int DEF_YEL  = 2
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       start_timer,
  input  logic [1:0] interval_address,
  input  logic       prg_sync_in,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       busy,
  output logic       one_hz_enable,
  output logic       o_dbg_state
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

`ifdef INTERVAL_CLAMP_EN
  localparam logic [3:0] RST_BASE = (DEF_BASE == 0) ? 4'd1 : 4'(DEF_BASE);
  localparam logic [3:0] RST_EXT  = (DEF_EXT  == 0) ? 4'd1 : 4'(DEF_EXT);
  localparam logic [3:0] RST_YEL  = (DEF_YEL  == 0) ? 4'd1 : 4'(DEF_YEL);
`else
  localparam logic [3:0] RST_BASE = 4'(DEF_BASE);
  localparam logic [3:0] RST_EXT  = 4'(DEF_EXT);
  localparam logic [3:0] RST_YEL  = 4'(DEF_YEL);
`endif

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_count, w_count_nxt;
  logic [PW-1:0]  r_presc, w_presc_nxt;
  logic           r_expired, w_expired_nxt;
  logic [3:0]     r_base, r_ext, r_yel;
  logic [3:0]     w_wr_data;
  logic [3:0]     w_load_val;
  logic           w_tick;

`ifdef INTERVAL_CLAMP_EN
  assign w_wr_data = (time_value == 4'd0) ? 4'd1 : time_value;
`else
  assign w_wr_data = time_value;
`endif

  assign w_tick = (r_presc == PRESC_LAST);

  always_comb begin
    case (interval_address)
      2'b01:   w_load_val = r_ext;
      2'b10:   w_load_val = r_yel;
      default: w_load_val = r_base;
    endcase
  end

  // Parameter register file. A held strobe rewrites every cycle.
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_base <= RST_BASE;
      r_ext  <= RST_EXT;
      r_yel  <= RST_YEL;
    end else if (prg_sync_in) begin
      case (time_param_sel)
        2'b00:   r_base <= w_wr_data;
        2'b01:   r_ext  <= w_wr_data;
        2'b10:   r_yel  <= w_wr_data;
        default: ;
      endcase
    end
  end

  // Next-state logic. Priority: program (abort) > start (load/restart) >
  // countdown. A zero load parks in COUNT with counter 0 for one cycle and
  // expires on the following edge without waiting for a tick.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_expired_nxt = 1'b0;
    w_presc_nxt   = w_tick ? '0 : r_presc + PW'(1);
    if (prg_sync_in) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = 4'd0;
    end else if (start_timer) begin
      w_state_nxt = S_COUNT;
      w_count_nxt = w_load_val;
      w_presc_nxt = '0;
    end else if (r_state == S_COUNT) begin
      if (r_count == 4'd0) begin
        w_state_nxt   = S_IDLE;
        w_expired_nxt = 1'b1;
      end else if (w_tick) begin
        w_count_nxt = r_count - 4'd1;
        if (r_count == 4'd1) begin
          w_state_nxt   = S_IDLE;
          w_expired_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_state   <= S_IDLE;
      r_count   <= 4'd0;
      r_presc   <= '0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_presc   <= w_presc_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  assign expired       = r_expired;
  // A zero-length load sits in COUNT with counter 0 and is not reported busy.
  assign busy          = (r_state == S_COUNT) && (r_count != 4'd0);
  assign one_hz_enable = w_tick;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_interval_timer.sv
// ---------------------------------------------------------------------------
// tb_interval_timer
//
// Bench for interval_timer with CLK_DIV = 4 and default parameters 6/3/2.
// A reference model works from start edges and deadlines (edge E + N*CLK_DIV,
// or E+1 for a zero interval). It predicts expired, busy and the tick phase,
// and those predictions are compared every cycle. Directed scenarios also
// check interval lengths and pulse counts against fixed constants.
// ---------------------------------------------------------------------------
module tb_interval_timer;

  localparam int DIV = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       sys_reset = 1'b0;
  logic       start_timer = 1'b0;
  logic [1:0] interval_address = 2'd0;
  logic       prg_sync_in = 1'b0;
  logic [1:0] time_param_sel = 2'd3;
  logic [3:0] time_value = 4'd0;
  logic       expired;
  logic       busy;
  logic       one_hz_enable;
  logic       dbg_state;

  interval_timer #(
    .CLK_DIV (DIV),
    .DEF_BASE(6),
    .DEF_EXT (3),
    .DEF_YEL (2)
  ) dut (
    .clk             (clk),
    .sys_reset       (sys_reset),
    .start_timer     (start_timer),
    .interval_address(interval_address),
    .prg_sync_in     (prg_sync_in),
    .time_param_sel  (time_param_sel),
    .time_value      (time_value),
    .expired         (expired),
    .busy            (busy),
    .one_hz_enable   (one_hz_enable),
    .o_dbg_state     (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int         cyc = 0;
  logic [3:0] m_reg [3];
  bit         m_active = 1'b0;
  bit         m_zero = 1'b0;
  int         m_deadline = 0;
  int         m_phase = 0;
  logic       m_exp = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_tick = 1'b0;

  function automatic logic [3:0] clampv(input logic [3:0] v);
`ifdef INTERVAL_CLAMP_EN
    return (v == 4'd0) ? 4'd1 : v;
`else
    return v;
`endif
  endfunction

  always @(posedge clk) begin
    int idx;
    logic [3:0] n_val;
    cyc++;
    if (!sys_reset) begin
      m_reg[0] = 4'd6; m_reg[1] = 4'd3; m_reg[2] = 4'd2;
      m_active = 1'b0; m_exp = 1'b0; m_busy = 1'b0; m_tick = 1'b0;
      m_phase = cyc;
    end else begin
      m_exp = m_active && (cyc == m_deadline) && !prg_sync_in && !start_timer;
      if (m_exp) m_active = 1'b0;
      if (prg_sync_in) begin
        if (time_param_sel != 2'd3) m_reg[int'(time_param_sel)] = clampv(time_value);
        m_active = 1'b0;
      end else if (start_timer) begin
        idx = (interval_address == 2'd3) ? 0 : int'(interval_address);
        n_val = m_reg[idx];
        m_active = 1'b1;
        m_zero = (n_val == 4'd0);
        m_deadline = m_zero ? cyc + 1 : cyc + int'(n_val) * DIV;
        m_phase = cyc;
      end
      m_busy = m_active && !m_zero;
      m_tick = (((cyc - m_phase) % DIV) == DIV - 1);
    end
  end

  // ---------------- scoreboard / observation ----------------
  logic [2:0]  got_q[$];
  logic [2:0]  want_q[$];
  int          cyc_q[$];
  logic [15:0] exp_q[$];
  int pulses = 0;
  int busy_cnt = 0;
  int last_rise = -1;

  // Driver: advance n cycles, sampling DUT and model at the falling edge.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got_q.push_back({expired, busy, one_hz_enable});
      want_q.push_back({m_exp, m_busy, m_tick});
      cyc_q.push_back(cyc);
      if (expired === 1'b1) begin pulses++; last_rise = cyc; end
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  task automatic clear_obs();
    pulses = 0; busy_cnt = 0; last_rise = -1;
  endtask

  task automatic do_start(input logic [1:0] addr, output int e);
    start_timer = 1'b1; interval_address = addr;
    e = cyc + 1;
    run_cycles(1);
    start_timer = 1'b0;
  endtask

  task automatic do_prog(input logic [1:0] sel, input logic [3:0] val);
    prg_sync_in = 1'b1; time_param_sel = sel; time_value = val;
    run_cycles(1);
    prg_sync_in = 1'b0; time_param_sel = 2'd3;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({expired, busy, one_hz_enable, dbg_state} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs exp/busy/tick/state got %b want 0000",
                 {expired, busy, one_hz_enable, dbg_state});
      end
    end
    #2 sys_reset = 1'b1;
  endtask

  task automatic test_defaults();
    int len [4] = '{24, 12, 8, 24};
    int e;
    for (int a = 0; a < 4; a++) begin
      clear_obs();
      exp_q.push_back(16'(len[a]));
      do_start(2'(a), e);
      run_cycles(len[a] + 3);
      n_checks++;
      if (16'(last_rise - e) !== exp_q.pop_front()) begin
        n_fail++; $display("FAIL defaults_len addr=%0d got %0d want %0d", a, last_rise - e, len[a]);
      end
      n_checks++;
      if (pulses !== 1) begin n_fail++; $display("FAIL defaults_pulses addr=%0d got %0d want 1", a, pulses); end
      n_checks++;
      if (busy_cnt !== len[a]) begin
        n_fail++; $display("FAIL defaults_busy addr=%0d got %0d want %0d", a, busy_cnt, len[a]);
      end
    end
    while (got_q.size() > 0) begin
      logic [2:0] g, w; int c;
      g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front();
      n_checks++;
      if (g !== w) begin n_fail++; $display("FAIL defaults_cycle cyc=%0d exp/busy/tick got %b want %b", c, g, w); end
    end
  endtask

  task automatic test_program();
    int e;
    clear_obs();
    do_prog(2'd2, 4'd5);
    run_cycles(2);
    do_start(2'd2, e);
    run_cycles(24);
    n_checks++;
    if (last_rise - e !== 20) begin n_fail++; $display("FAIL program_len got %0d want 20", last_rise - e); end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL program_pulses got %0d want 1", pulses); end
    while (got_q.size() > 0) begin
      logic [2:0] g, w; int c;
      g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front();
      n_checks++;
      if (g !== w) begin n_fail++; $display("FAIL program_cycle cyc=%0d exp/busy/tick got %b want %b", c, g, w); end
    end
  endtask

  task automatic test_restart();
    int e1, e2;
    clear_obs();
    do_start(2'd0, e1);
    run_cycles(9);
    do_start(2'd1, e2);
    run_cycles(20);
    n_checks++;
    if (e2 - e1 !== 10) begin n_fail++; $display("FAIL restart_spacing got %0d want 10", e2 - e1); end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL restart_pulses got %0d want 1", pulses); end
    n_checks++;
    if (last_rise - e1 !== 22) begin n_fail++; $display("FAIL restart_rise got %0d want 22", last_rise - e1); end
    while (got_q.size() > 0) begin
      logic [2:0] g, w; int c;
      g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front();
      n_checks++;
      if (g !== w) begin n_fail++; $display("FAIL restart_cycle cyc=%0d exp/busy/tick got %b want %b", c, g, w); end
    end
  endtask

  task automatic test_prog_vs_start();
    int e;
    clear_obs();
    prg_sync_in = 1'b1; time_param_sel = 2'd1; time_value = 4'd2;
    start_timer = 1'b1; interval_address = 2'd1;
    run_cycles(1);
    prg_sync_in = 1'b0; time_param_sel = 2'd3; start_timer = 1'b0;
    run_cycles(12);
    n_checks++;
    if (pulses !== 0 || busy_cnt !== 0) begin
      n_fail++; $display("FAIL prg_start_ignored pulses/busy got %0d/%0d want 0/0", pulses, busy_cnt);
    end
    clear_obs();
    do_start(2'd1, e);
    run_cycles(11);
    n_checks++;
    if (last_rise - e !== 8) begin n_fail++; $display("FAIL prg_written_len got %0d want 8", last_rise - e); end
    clear_obs();
    do_start(2'd0, e);
    run_cycles(6);
    do_prog(2'd3, 4'd9);
    run_cycles(30);
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL prg_abort_pulses got %0d want 0", pulses); end
    while (got_q.size() > 0) begin
      logic [2:0] g, w; int c;
      g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front();
      n_checks++;
      if (g !== w) begin n_fail++; $display("FAIL prg_start_cycle cyc=%0d exp/busy/tick got %b want %b", c, g, w); end
    end
  endtask

  task automatic test_zero();
    int e;
`ifdef INTERVAL_CLAMP_EN
    int want_len = 4;
    int want_busy = 4;
`else
    int want_len = 1;
    int want_busy = 0;
`endif
    do_prog(2'd1, 4'd0);
    clear_obs();
    do_start(2'd1, e);
    run_cycles(8);
    n_checks++;
    if (last_rise - e !== want_len) begin
      n_fail++; $display("FAIL zero_len got %0d want %0d", last_rise - e, want_len);
    end
    n_checks++;
    if (busy_cnt !== want_busy || pulses !== 1) begin
      n_fail++; $display("FAIL zero_busy_pulses got %0d/%0d want %0d/1", busy_cnt, pulses, want_busy);
    end
    while (got_q.size() > 0) begin
      logic [2:0] g, w; int c;
      g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front();
      n_checks++;
      if (g !== w) begin n_fail++; $display("FAIL zero_cycle cyc=%0d exp/busy/tick got %b want %b", c, g, w); end
    end
  endtask

  task automatic test_async_reset();
    int e;
    do_prog(2'd1, 4'd9);
    do_start(2'd0, e);
    run_cycles(10);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL areset_pre_busy got %b want 1", busy); end
    #2 sys_reset = 1'b0;
    #1;
    n_checks++;
    if ({expired, busy, dbg_state} !== 3'b000) begin
      n_fail++; $display("FAIL areset_immediate exp/busy/state got %b want 000", {expired, busy, dbg_state});
    end
    run_cycles(3);
    #2 sys_reset = 1'b1;
    clear_obs();
    run_cycles(30);
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL areset_no_expire got %0d want 0", pulses); end
    clear_obs();
    do_start(2'd1, e);
    run_cycles(15);
    n_checks++;
    if (last_rise - e !== 12) begin n_fail++; $display("FAIL areset_ext_default got %0d want 12", last_rise - e); end
    while (got_q.size() > 0) begin
      logic [2:0] g, w; int c;
      g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front();
      n_checks++;
      if (g !== w) begin n_fail++; $display("FAIL areset_cycle cyc=%0d exp/busy/tick got %b want %b", c, g, w); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      start_timer      = ($urandom_range(0, 29) == 0);
      prg_sync_in      = ($urandom_range(0, 69) == 0);
      interval_address = 2'($urandom_range(0, 3));
      time_param_sel   = 2'($urandom_range(0, 3));
      time_value       = 4'($urandom_range(0, 15));
      run_cycles(1);
    end
    start_timer = 1'b0; prg_sync_in = 1'b0; time_param_sel = 2'd3;
    run_cycles(70);
    while (got_q.size() > 0) begin
      logic [2:0] g, w; int c;
      g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front();
      n_checks++;
      if (g !== w) begin n_fail++; $display("FAIL random_cycle cyc=%0d exp/busy/tick got %b want %b", c, g, w); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_defaults();
    test_program();
    test_restart();
    test_prog_vs_start();
    test_zero();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
